// File: rtl/arb_mux.sv
// ============================================================================
// arb_mux -- parametrised N:1 channel selector with valid/ready handshakes
//
// Picks one of CHANNELS producer streams, either by an external index (fixed
// mode) or by round-robin arbitration, and holds the winning word in a
// one-entry output register until the consumer takes it. A drain and a new
// accept can happen in the same cycle, so one word per cycle flows when the
// consumer keeps out_ready high.
//
// Optional feature macro: ARB_MUX_LOCK_EN
//   When defined, a `lock` input is present. A round-robin accept with lock=1
//   pins the grant to the last winner until an accept with lock=0 (or any
//   fixed-mode accept) releases it.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   mode       in   0 = fixed select via sel, 1 = round-robin
//   sel        in   channel index used in fixed mode (>= CHANNELS never grants)
//   in_valid   in   per-channel valid
//   in_data    in   flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_ready   out  per-channel ready, one-hot or zero
//   out_valid  out  output register holds a word
//   out_data   out  registered data word
//   out_chan   out  index of the channel that supplied out_data
//   out_ready  in   consumer takes the word when high with out_valid
//   lock       in   grant lock request (ARB_MUX_LOCK_EN only)
// ============================================================================
module arb_mux #(
    parameter int  WIDTH    = 8,
    parameter int  CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    input  logic                      out_ready
`ifdef ARB_MUX_LOCK_EN
    ,
    input  logic                      lock
`endif
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_chan_q,  out_chan_d;
    // Last round-robin winner; the scan starts just above it.
    logic [SEL_W-1:0] ptr_q,       ptr_d;
`ifdef ARB_MUX_LOCK_EN
    logic             locked_q,    locked_d;
`endif

    logic             space;
    logic             grant_vld;
    logic [SEL_W-1:0] grant;
    logic             accept;
    logic [WIDTH-1:0] grant_data;

    // The register can take a word if it is empty or being drained this cycle.
    assign space  = !out_valid_q || out_ready;
    assign accept = space && grant_vld;

    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        if (!mode) begin
            // Comparing against every legal index means an out-of-range sel
            // simply matches nothing.
            for (int i = 0; i < CHANNELS; i++) begin
                if (!grant_vld && sel == SEL_W'(i) && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant     = SEL_W'(i);
                end
            end
        end
`ifdef ARB_MUX_LOCK_EN
        else if (locked_q) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!grant_vld && ptr_q == SEL_W'(i) && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant     = SEL_W'(i);
                end
            end
        end
`endif
        else begin
            // Two ascending passes give the wrapped order ptr+1 .. N-1, 0 .. ptr.
            for (int i = 0; i < CHANNELS; i++) begin
                if (!grant_vld && SEL_W'(i) > ptr_q && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant     = SEL_W'(i);
                end
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (!grant_vld && SEL_W'(i) <= ptr_q && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant     = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Ready is forced low while reset is held so no producer sees a handshake.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = rst_n && accept && (grant == SEL_W'(i));
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
`ifdef ARB_MUX_LOCK_EN
        locked_d    = locked_q;
`endif
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_chan_d  = grant;
            if (mode) begin
                ptr_d = grant;
            end
`ifdef ARB_MUX_LOCK_EN
            locked_d = mode && lock;
`endif
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= SEL_W'(CHANNELS - 1);
`ifdef ARB_MUX_LOCK_EN
            locked_q    <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
`ifdef ARB_MUX_LOCK_EN
            locked_q    <= locked_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_arb_mux.sv
// ============================================================================
// tb_arb_mux -- self-checking bench for arb_mux (WIDTH=8, CHANNELS=4 main
// instance, plus a CHANNELS=3 instance for the out-of-range select case).
// A behavioural model tracks the output register and the arbitration pointer
// and predicts in_ready and the registered outputs each cycle.
// ============================================================================
module tb_arb_mux;

`ifdef ARB_MUX_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_ready;
    logic        lock;

    logic        mode3;
    logic [1:0]  sel3;
    logic [2:0]  in_valid3;
    logic [23:0] in_data3;
    logic [2:0]  in_ready3;
    logic        out_valid3;
    logic [7:0]  out_data3;
    logic [1:0]  out_chan3;
    logic        out_ready3;

    arb_mux #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
        .out_ready(out_ready)
`ifdef ARB_MUX_LOCK_EN
        , .lock(lock)
`endif
    );

    arb_mux #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_chan(out_chan3),
        .out_ready(out_ready3)
`ifdef ARB_MUX_LOCK_EN
        , .lock(1'b0)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    bit       m_valid;
    bit [7:0] m_data;
    int       m_chan;
    int       m_ptr;
    bit       m_locked;

    task automatic model_reset();
        m_valid  = 1'b0;
        m_data   = 8'h00;
        m_chan   = 0;
        m_ptr    = 3;
        m_locked = 1'b0;
    endtask

    // Channel chosen this cycle from the rules, or -1 for none.
    function automatic int ref_grant();
        int g;
        g = -1;
        if (!mode) begin
            if (in_valid[sel]) g = int'(sel);
        end else if (LOCK_ON && m_locked) begin
            if (in_valid[m_ptr]) g = m_ptr;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (g < 0 && in_valid[c]) g = c;
            end
        end
        return g;
    endfunction

    function automatic logic [3:0] ref_ready();
        int g;
        g = ref_grant();
        if (!rst_n || (m_valid && !out_ready) || g < 0) return 4'b0000;
        return 4'(1 << g);
    endfunction

    // Advance one clock edge and step the model with the inputs seen there.
    task automatic tick();
        int g;
        bit acc;
        g   = ref_grant();
        acc = rst_n && (!m_valid || out_ready) && (g >= 0);
        @(posedge clk);
        if (acc) begin
            m_data  = in_data[g*8 +: 8];
            m_chan  = g;
            m_valid = 1'b1;
            if (mode) begin
                m_ptr    = g;
                m_locked = lock;
            end else begin
                m_locked = 1'b0;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = 2'd0;
        in_valid  = 4'h0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        lock      = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        n_cmp++; if (out_chan !== 2'd0) begin n_fail++; $display("FAIL reset_out_chan: got %0d want 0", out_chan); end
        // Fill the register, then reset with the word still held.
        mode = 1'b0; sel = 2'd1; in_valid = 4'hF; in_data = 32'h4433_2211; out_ready = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h22) begin n_fail++; $display("FAIL reset_preload: got v=%0b d=%h want v=1 d=22", out_valid, out_data); end
        mode = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_valid: got %0b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_mid_data: got %h want 00", out_data); end
        n_cmp++; if (out_chan !== 2'd0) begin n_fail++; $display("FAIL reset_mid_chan: got %0d want 0", out_chan); end
        n_cmp++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_mid_ready: got %b want 0000", in_ready); end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b want 0001", in_ready); end
        tick();
        n_cmp++; if (out_chan !== 2'd0 || out_data !== 8'h11) begin n_fail++; $display("FAIL reset_first_word: got ch=%0d d=%h want ch=0 d=11", out_chan, out_data); end
    endtask

    task automatic test_fixed();
        do_reset();
        mode = 1'b0; sel = 2'd2; in_valid = 4'hF; in_data = 32'h11A5_3344; out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL fixed_ready: got %b want 0100", in_ready); end
        tick();
        n_cmp++; if (out_data !== 8'hA5 || out_chan !== 2'd2 || out_valid !== 1'b1) begin n_fail++; $display("FAIL fixed_word: got v=%0b d=%h ch=%0d want v=1 d=a5 ch=2", out_valid, out_data, out_chan); end
        // Fixed accept leaves the round-robin pointer alone: channel 0 still first.
        mode = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL fixed_keeps_ptr: got %b want 0001", in_ready); end
        mode = 1'b0;
        // CHANNELS=3 instance: sel=3 is out of range.
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; in_data3 = 24'hC3_2211; out_ready3 = 1'b1;
        #1;
        n_cmp++; if (in_ready3 !== 3'b000) begin n_fail++; $display("FAIL fixed_oor_ready: got %b want 000", in_ready3); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid3 !== 1'b0) begin n_fail++; $display("FAIL fixed_oor_valid: got %0b want 0", out_valid3); end
        sel3 = 2'd2;
        #1;
        n_cmp++; if (in_ready3 !== 3'b100) begin n_fail++; $display("FAIL fixed3_ready: got %b want 100", in_ready3); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid3 !== 1'b1 || out_data3 !== 8'hC3 || out_chan3 !== 2'd2) begin n_fail++; $display("FAIL fixed3_word: got v=%0b d=%h ch=%0d want v=1 d=c3 ch=2", out_valid3, out_data3, out_chan3); end
        in_valid3 = 3'b000;
    endtask

    task automatic test_rr_rotation();
        do_reset();
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = $urandom;
            tick();
            n_cmp++; if (out_chan !== 2'(i % 4) || out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_rotation[%0d]: got v=%0b ch=%0d want v=1 ch=%0d", i, out_valid, out_chan, i % 4); end
            n_cmp++; if (out_data !== m_data) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", i, out_data, m_data); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; in_data = 32'h0000_3C00; out_ready = 1'b1;
        tick();
        out_ready = 1'b0; in_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            in_data = $urandom;
            #1;
            n_cmp++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b want 0000", i, in_ready); end
            tick();
            n_cmp++; if (out_data !== 8'h3C || out_valid !== 1'b1 || out_chan !== 2'd1) begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%0b d=%h ch=%0d want v=1 d=3c ch=1", i, out_valid, out_data, out_chan); end
        end
        out_ready = 1'b1; sel = 2'd3; in_data = 32'h5A00_0000;
        #1;
        n_cmp++; if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL release_ready: got %b want 1000", in_ready); end
        tick();
        n_cmp++; if (out_data !== 8'h5A || out_chan !== 2'd3 || out_valid !== 1'b1) begin n_fail++; $display("FAIL release_word: got v=%0b d=%h ch=%0d want v=1 d=5a ch=3", out_valid, out_data, out_chan); end
        in_valid = 4'h0; in_data = 32'hFFFF_FFFF;
        tick();
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h5A || out_chan !== 2'd3) begin n_fail++; $display("FAIL drain_only: got v=%0b d=%h ch=%0d want v=0 d=5a ch=3", out_valid, out_data, out_chan); end
    endtask

    task automatic test_sparse();
        int exp_seq[3] = '{3, 1, 3};
        do_reset();
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0010; in_data = 32'h0403_0201;
        tick();
        n_cmp++; if (out_chan !== 2'd1) begin n_fail++; $display("FAIL sparse_setup: got ch=%0d want 1", out_chan); end
        in_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (out_chan !== 2'(exp_seq[i])) begin n_fail++; $display("FAIL sparse_13[%0d]: got ch=%0d want %0d", i, out_chan, exp_seq[i]); end
        end
        in_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            in_data = $urandom;
            tick();
            n_cmp++; if (out_chan !== 2'd0 || out_valid !== 1'b1 || out_data !== in_data[7:0]) begin n_fail++; $display("FAIL sparse_0[%0d]: got v=%0b ch=%0d d=%h want v=1 ch=0 d=%h", i, out_valid, out_chan, out_data, in_data[7:0]); end
        end
    endtask

`ifdef ARB_MUX_LOCK_EN
    task automatic test_lock();
        int exp_seq[4]  = '{2, 2, 2, 3};
        bit lock_seq[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'hF; in_data = 32'h4433_2211;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            lock = lock_seq[i];
            tick();
            n_cmp++; if (out_chan !== 2'(exp_seq[i])) begin n_fail++; $display("FAIL lock_seq[%0d]: got ch=%0d want %0d", i, out_chan, exp_seq[i]); end
        end
        lock = 1'b0;
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            lock      = LOCK_ON ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            n_cmp++; if (in_ready !== ref_ready()) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", i, in_ready, ref_ready()); end
            tick();
            n_cmp++; if (out_valid !== m_valid || out_data !== m_data || out_chan !== 2'(m_chan)) begin n_fail++; $display("FAIL rand_out[%0d]: got v=%0b d=%h ch=%0d want v=%0b d=%h ch=%0d", i, out_valid, out_data, out_chan, m_valid, m_data, m_chan); end
        end
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = 4'h0; in_data = 32'h0;
        out_ready = 1'b0; lock = 1'b0;
        mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b000; in_data3 = 24'h0; out_ready3 = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_fixed();
        test_rr_rotation();
        test_backpressure();
        test_sparse();
`ifdef ARB_MUX_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised N:1 channel selector with valid/ready handshakes and a registered output stage; next generation of the team's fixed 4:1 combinational mux. Selects one of CHANNELS input streams either by an external select (fixed mode) or by round-robin arbitration, and holds the winning word in a one-entry output register until the consumer takes it. Sits between multiple producers (e.g. operand/tape sources) and a single consumer in the processor datapath.

## Interface
- WIDTH, 8: data bits per channel.
- CHANNELS, 4: number of input channels, legal 2..16.
- SEL_W, $clog2(CHANNELS): select/channel-index width (derived, not overridden).

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SEL_W  channel index used in fixed mode.
- in_valid  in  CHANNELS  per-channel valid.
- in_data  in  CHANNELS*WIDTH  flattened data; channel i at [i*WIDTH +: WIDTH].
- in_ready  out  CHANNELS  per-channel ready, one-hot or zero.
- out_valid  out  1  output register holds a word.
- out_data  out  WIDTH  registered data.
- out_chan  out  SEL_W  index of channel that supplied out_data.
- out_ready  in  1  consumer accepts word when high with out_valid.
- lock  in  1  grant lock request (present only with ARB_MUX_LOCK_EN).

## Operation
- Reset: out_valid=0, out_data=0, out_chan=0, round-robin pointer ptr=CHANNELS-1 (channel 0 highest priority first), locked=0.
- space = !out_valid || out_ready (combinational).
- Grant (combinational, current-cycle mode/sel/in_valid):
  - Fixed: grant=sel if sel<CHANNELS and in_valid[sel]; else none. sel>=CHANNELS never grants.
  - Round-robin: first i with in_valid[i], scanning ptr+1, ptr+2, ... wrapping modulo CHANNELS, ptr itself last.
- in_ready[i] = space && grant valid && grant==i. in_ready never depends on in_valid[i] of the same channel except via grant.
- Accept (any in_valid[i]&&in_ready[i]): out_data<=in_data[i], out_chan<=i, out_valid<=1; in round-robin mode ptr<=i. Fixed-mode accepts leave ptr unchanged.
- Drain without accept (out_valid&&out_ready, no grant): out_valid<=0; out_data/out_chan hold.
- Simultaneous drain and accept: new word loaded, out_valid stays 1 (full throughput).
- Output stall (out_valid&&!out_ready): out_data, out_chan stable; all in_ready=0.
- Mode change takes effect on the grant of the same cycle; ptr retained across mode changes.
- Reset mid-transfer: word in output register discarded, state as reset.

## Timing
- Latency: input accepted on edge N appears on out_data after edge N, 1 cycle.
- Throughput: one word per cycle with out_ready held high.
- Combinational paths: out_ready -> in_ready, in_valid/sel/mode -> in_ready. No path from in_data to any output except through the register.
- out_valid must not drop without a handshake; out_data must not change while out_valid&&!out_ready.

## Configuration
- ARB_MUX_LOCK_EN defined: lock port present. Round-robin accept with lock=1 sets locked<=1; while locked, grant is only ptr (granted iff in_valid[ptr]), other channels starve. Accept with lock=0 clears locked. Fixed mode ignores lock and clears locked on any accept.
- Undefined: no lock port, no locked register; behaviour identical to lock tied 0.

## Test plan
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_chan=0, in_ready=0 immediately; after release, RR with all valid grants channel 0 first.
- Fixed mode, CHANNELS=4, sel=2, in_data[2]=8'hA5, all valid, out_ready=1 -> in_ready=4'b0100, next cycle out_data=8'hA5, out_chan=2; sel=3'd? out of range (CHANNELS=3, sel=3) -> no grant.
- Round-robin, all four valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0,1 one per cycle, out_valid held 1.
- Backpressure: out_ready=0 for 3 cycles with word 8'h3C held -> out_data=8'h3C stable, in_ready=0; out_ready=1 -> drain and new accept same cycle.
- Sparse RR: only channels 1 and 3 valid, ptr=1 -> grant 3 then 1 then 3; only channel 0 valid -> granted every cycle.
- ARB_MUX_LOCK_EN: RR, grant channel 2 with lock=1 for 3 accepts while all valid -> out_chan 2,2,2; lock=0 on third accept -> next grant channel 3.
